// File: rtl/complex_stream_requantizer.sv
// rtl/complex_stream_requantizer.sv - requantizes a wide complex AXI-Stream to a narrow one
// Stage 1 rounds/shifts/saturates on accept, stage 2 pushes into a small output FIFO.
module complex_stream_requantizer #(
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 16,
  parameter int ROUND        = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int BYTE_ALIGNED = 1,
  localparam int EFF_IN  = (BYTE_ALIGNED != 0) ? ((2*IN_WIDTH+15)/16)*16 : 2*IN_WIDTH,
  localparam int EFF_OUT = (BYTE_ALIGNED != 0) ? ((2*OUT_WIDTH+15)/16)*16 : 2*OUT_WIDTH
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [EFF_IN-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [EFF_OUT-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               clear_stats,
  output logic [15:0]        sat_count,
  output logic               overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int HALF_OUT = EFF_OUT / 2;
  localparam int RSH      = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_WIDTH:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((IN_WIDTH+1)'(1) << RSH) : '0;
  localparam logic signed [IN_WIDTH:0] MAXV =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FIFO_DEPTH);

  // Returns {clamped, value}; one extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH:0] requant(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] sh;
    ext = $signed({x[IN_WIDTH-1], x}) + $signed(RND);
    sh  = ext >>> SHIFT;
    if (sh > MAXV)
      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (sh < MINV)
      return {1'b1, MINV[OUT_WIDTH-1:0]};
    else
      return {1'b0, sh[OUT_WIDTH-1:0]};
  endfunction

  logic [OUT_WIDTH:0]     q_re, q_im;
  logic [OUT_WIDTH-1:0]   pipe_re, pipe_im;
  logic                   pipe_valid;
  logic [2*OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [AW+1:0]          occupancy;
  logic [1:0]             n_sat;
  logic [16:0]            sat_sum;
  logic [2*OUT_WIDTH-1:0] head;
  logic                   fire, pop;

  assign q_re = requant(s_axis_tdata[IN_WIDTH-1:0]);
  assign q_im = requant(s_axis_tdata[EFF_IN/2+IN_WIDTH-1:EFF_IN/2]);

  // The pipe slot counts as occupied so an accepted sample always has a FIFO entry waiting.
  assign occupancy     = {1'b0, count} + (AW+2)'(pipe_valid);
  assign s_axis_tready = aresetn && (occupancy < DEPTH_L);
  assign fire          = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign head          = mem[rd_ptr];
  assign m_axis_tdata  = {HALF_OUT'($signed(head[2*OUT_WIDTH-1:OUT_WIDTH])),
                          HALF_OUT'($signed(head[OUT_WIDTH-1:0]))};

  assign n_sat   = {1'b0, q_re[OUT_WIDTH]} + {1'b0, q_im[OUT_WIDTH]};
  assign sat_sum = {1'b0, sat_count} + 17'(n_sat);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pipe_valid <= 1'b0;
      pipe_re    <= '0;
      pipe_im    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sat_count  <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pipe_valid <= fire;
      if (fire) begin
        pipe_re <= q_re[OUT_WIDTH-1:0];
        pipe_im <= q_im[OUT_WIDTH-1:0];
      end
      if (pipe_valid) begin
        mem[wr_ptr] <= {pipe_im, pipe_re};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({pipe_valid, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (clear_stats) begin
        sat_count <= '0;
        overflow  <= 1'b0;
      end else if (fire && n_sat != 2'd0) begin
        sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/complex_stream_requantizer.md
Name: complex_stream_requantizer

Overview:
- AXI-Stream sink for the complex multiplier's wide output stream: accepts full-precision complex products, requantizes each component to a narrower width and re-emits them as a narrow complex stream.
- Requantization is arithmetic shift, optional rounding, then saturation with overflow statistics.
- A small output FIFO absorbs downstream back-pressure, so upstream sees clean tready flow control instead of data-dropping stalls.
- Sits between the multiplier output and narrow consumers such as DAC paths or FFT inputs.

Parameters:
- IN_WIDTH, 32, input component width (even).
- OUT_WIDTH, 16, output component width (even, < IN_WIDTH).
- SHIFT, 16, arithmetic right shift applied before saturation (0..IN_WIDTH-1).
- ROUND, 1, 0 = truncate toward -inf; 1 = round half up (add 2^(SHIFT-1) before shift; ignored when SHIFT=0).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).
- BYTE_ALIGNED, 1, port packing rule. EFF_IN = BYTE_ALIGNED ? ((2*IN_WIDTH+15)/16)*16 : 2*IN_WIDTH. EFF_OUT is defined the same way from OUT_WIDTH.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low; clock aclk.
- s_axis_tdata  in  EFF_IN  real at [IN_WIDTH-1:0], imag at [EFF_IN/2+IN_WIDTH-1:EFF_IN/2], both signed.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  EFF_OUT  real in the low half, imag in the high half, each sign-extended to EFF_OUT/2.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- clear_stats  in  1  synchronous clear of sat_count and overflow.
- sat_count  out  16  count of saturated components; saturates at 0xFFFF.
- overflow  out  1  sticky, set on any saturation.

Behaviour:
- Reset (aresetn=0 at posedge): FIFO emptied, pipe_valid=0, m_axis_tvalid=0, m_axis_tdata=0, sat_count=0, overflow=0. s_axis_tready is 0 while aresetn=0 and goes to 1 in the first cycle after release.
- Reset mid-operation discards all in-flight and buffered samples; nothing is output after release.
- Handshake: a transfer occurs when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = aresetn && (count + pipe_valid < FIFO_DEPTH).
  - s_axis_tready is derived only from registered state: no combinational path from m_axis_tready or s_axis_tvalid.
- Stage 1 (accept edge): each component is sign-extended to IN_WIDTH+1 bits, rounding constant added if enabled, shifted right arithmetically by SHIFT, then clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Result and pipe_valid=1 are registered.
- Stage 2: if pipe_valid, the stage-1 result is written to the FIFO tail. pipe_valid clears when no new transfer occurs.
- Output: m_axis_tvalid = (count != 0). m_axis_tdata = FIFO head. Head pops on m_axis_tvalid && m_axis_tready.
- m_axis_tdata and m_axis_tvalid must stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Latency: sample accepted at edge N is visible on m_axis_tvalid/m_axis_tdata in the cycle after edge N+1 (2 cycles) when the FIFO is empty.
- Ordering is strictly FIFO. No samples are dropped or duplicated under any tvalid/tready pattern.
- Simultaneous push and pop in one cycle leaves count unchanged; an empty FIFO never pops.
- Throughput: with m_axis_tready held 1 and s_axis_tvalid held 1, one sample per cycle is sustained indefinitely.
- Statistics:
  - sat_count increments by the number of components (0, 1 or 2) clamped in stage 1 that cycle, capped at 0xFFFF.
  - overflow is set by any clamp.
  - clear_stats takes priority over increments in the same cycle: result 0/0.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Rounding (defaults): real=0x0001_8000, imag=0xFFFF_7FFF, m_axis_tready=1 -> m_axis_tdata=0xFFFF_0002 two cycles after acceptance; sat_count=0.
- Saturation: real=0x7FFF_FFFF, imag=0x8000_0000 -> m_axis_tdata=0x8000_7FFF, sat_count=1, overflow=1. Next cycle, clear_stats=1 -> both 0.
- Back-pressure: m_axis_tready=0, 6 distinct samples offered back-to-back -> exactly 4 accepted, s_axis_tready low afterwards. Raise m_axis_tready -> 4 outputs in order, then remaining 2 accepted and output, no loss or duplication.
- Streaming: 100 consecutive samples, both valids/readies held 1 -> s_axis_tready never drops, 100 outputs in order, one per cycle after a 2-cycle fill.
- Random stall: random m_axis_tready (50%) and s_axis_tvalid (70%) over 1000 samples -> output matches the scoreboard reference model. m_axis_tdata holds stable during every stall.
- Reset mid-operation: FIFO holds 3 samples with sat_count=5, pulse aresetn=0 for 1 cycle -> m_axis_tvalid=0, sat_count=0, overflow=0, s_axis_tready=1 the next cycle, none of the old samples appear.
